// File: rtl/updown_counter_pkg.sv
// ---------------------------------------------------------------------------
// updown_counter_pkg
//   Shared types for the up/down counter bank.
//   op_t      : per-channel operation selected for the current cycle
//   mode_t    : end-of-range behaviour (wrap around or saturate)
//   decode_op : resolves the load/inc/dec strobes into one operation.
//               Priority is load, then exactly one of inc/dec, then hold.
// ---------------------------------------------------------------------------
package updown_counter_pkg;

    typedef enum logic [1:0] {OP_HOLD, OP_INC, OP_DEC, OP_LOAD} op_t;
    typedef enum logic {MODE_WRAP, MODE_SAT} mode_t;

    function automatic op_t decode_op(input logic load, input logic inc, input logic dec);
        if (load)
            return OP_LOAD;
        if (inc && !dec)
            return OP_INC;
        if (dec && !inc)
            return OP_DEC;
        return OP_HOLD;  // no strobe, or inc and dec cancel each other
    endfunction

endpackage

// File: rtl/updown_counter_bank_channel.sv
// ---------------------------------------------------------------------------
// updown_counter_channel
//   One modulo-COUNT up/down counter with parallel load and wrap/saturate mode.
//   Ports:
//     clock, reset_n         : clock, synchronous active-low reset
//     i_inc, i_dec, i_load   : strobes (load > inc^dec > hold)
//     i_load_val [WIDTH]     : load value, clamped to COUNT-1
//     i_sat                  : 0 = wrap, 1 = saturate
//     o_count [WIDTH]        : registered count
//     o_wrap_up, o_wrap_dn   : registered one-cycle wrap pulses
//     o_wrap_up_cond/_dn_cond: combinational "wrapping this cycle" (carry out)
//     o_at_max, o_at_zero    : decode of the registered count
// ---------------------------------------------------------------------------
module updown_counter_channel
    import updown_counter_pkg::*;
#(
    parameter int COUNT = 16,
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_sat,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap_up,
    output logic             o_wrap_dn,
    output logic             o_wrap_up_cond,
    output logic             o_wrap_dn_cond,
    output logic             o_at_max,
    output logic             o_at_zero
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(COUNT - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap_up;
    logic             r_wrap_dn;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_wrap_up;
    logic             w_wrap_dn;
    op_t              w_op;
    mode_t            w_mode;

    assign w_op   = decode_op(i_load, i_inc, i_dec);
    assign w_mode = mode_t'(i_sat);

    // When COUNT fills the WIDTH-bit range no load value can exceed COUNT-1,
    // so the clamp comparator is only built for non-power-of-two moduli.
    generate
        if ((1 << WIDTH) > COUNT) begin : g_clamp
            assign w_load_clamped = (i_load_val > MAX_VAL) ? MAX_VAL : i_load_val;
        end else begin : g_no_clamp
            assign w_load_clamped = i_load_val;
        end
    endgenerate

    always_comb begin
        w_count_next = r_count;
        w_wrap_up    = 1'b0;
        w_wrap_dn    = 1'b0;
        case (w_op)
            OP_LOAD: w_count_next = w_load_clamped;
            OP_INC: begin
                if (r_count != MAX_VAL) begin
                    w_count_next = r_count + 1'b1;
                end else if (w_mode == MODE_WRAP) begin
                    w_count_next = '0;
                    w_wrap_up    = 1'b1;
                end
            end
            OP_DEC: begin
                if (r_count != '0) begin
                    w_count_next = r_count - 1'b1;
                end else if (w_mode == MODE_WRAP) begin
                    w_count_next = MAX_VAL;
                    w_wrap_dn    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_wrap_up <= 1'b0;
            r_wrap_dn <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_wrap_up <= w_wrap_up;
            r_wrap_dn <= w_wrap_dn;
        end
    end

    assign o_count        = r_count;
    assign o_wrap_up      = r_wrap_up;
    assign o_wrap_dn      = r_wrap_dn;
    assign o_wrap_up_cond = w_wrap_up;
    assign o_wrap_dn_cond = w_wrap_dn;
    assign o_at_max       = (r_count == MAX_VAL);
    assign o_at_zero      = (r_count == '0);

endmodule

// File: rtl/updown_counter_bank.sv
// ---------------------------------------------------------------------------
// updown_counter_bank
//   Bank of CHANNELS modulo-COUNT up/down counters (one
//   updown_counter_channel each). Channel k uses bits [k*WIDTH +: WIDTH] of the
//   packed i_load_val / o_count buses.
//   Ports: clock, reset_n (sync, active-low), i_inc, i_dec, i_load, i_sat
//   [CHANNELS], i_load_val [CHANNELS*WIDTH], o_count [CHANNELS*WIDTH],
//   o_wrap_up, o_wrap_dn, o_at_max, o_at_zero [CHANNELS].
//   Build option UPDOWN_COUNTER_CASCADE_EN: channel k>0 additionally counts
//   up/down on the same-cycle wrap of channel k-1 (multi-digit counter,
//   channel 0 least significant). Without it channels are independent.
// ---------------------------------------------------------------------------
module updown_counter_bank
    import updown_counter_pkg::*;
#(
    parameter int  COUNT    = 16,
    parameter int  CHANNELS = 4,
    localparam int WIDTH    = (COUNT <= 2) ? 1 : $clog2(COUNT)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       i_inc,
    input  logic [CHANNELS-1:0]       i_dec,
    input  logic [CHANNELS-1:0]       i_load,
    input  logic [CHANNELS*WIDTH-1:0] i_load_val,
    input  logic [CHANNELS-1:0]       i_sat,
    output logic [CHANNELS*WIDTH-1:0] o_count,
    output logic [CHANNELS-1:0]       o_wrap_up,
    output logic [CHANNELS-1:0]       o_wrap_dn,
    output logic [CHANNELS-1:0]       o_at_max,
    output logic [CHANNELS-1:0]       o_at_zero
);

    logic [CHANNELS-1:0] w_inc_eff;
    logic [CHANNELS-1:0] w_dec_eff;
    logic [CHANNELS-1:0] w_wrap_up_cond;
    logic [CHANNELS-1:0] w_wrap_dn_cond;
    logic                w_unused_cond;

    // The last channel's carry (and every carry in the independent build)
    // has no consumer.
    assign w_unused_cond = ^{w_wrap_up_cond, w_wrap_dn_cond};

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
`ifdef UPDOWN_COUNTER_CASCADE_EN
            if (gi == 0) begin : g_lsd
                assign w_inc_eff[gi] = i_inc[gi];
                assign w_dec_eff[gi] = i_dec[gi];
            end else begin : g_carry
                // Carry ripples combinationally; a load below produces no carry
                // because the wrap condition is only raised for inc/dec ops.
                assign w_inc_eff[gi] = i_inc[gi] | w_wrap_up_cond[gi-1];
                assign w_dec_eff[gi] = i_dec[gi] | w_wrap_dn_cond[gi-1];
            end
`else
            assign w_inc_eff[gi] = i_inc[gi];
            assign w_dec_eff[gi] = i_dec[gi];
`endif
            updown_counter_channel #(
                .COUNT (COUNT),
                .WIDTH (WIDTH)
            ) u_channel (
                .clock          (clock),
                .reset_n        (reset_n),
                .i_inc          (w_inc_eff[gi]),
                .i_dec          (w_dec_eff[gi]),
                .i_load         (i_load[gi]),
                .i_load_val     (i_load_val[gi*WIDTH +: WIDTH]),
                .i_sat          (i_sat[gi]),
                .o_count        (o_count[gi*WIDTH +: WIDTH]),
                .o_wrap_up      (o_wrap_up[gi]),
                .o_wrap_dn      (o_wrap_dn[gi]),
                .o_wrap_up_cond (w_wrap_up_cond[gi]),
                .o_wrap_dn_cond (w_wrap_dn_cond[gi]),
                .o_at_max       (o_at_max[gi]),
                .o_at_zero      (o_at_zero[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_updown_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_bank
//   Main DUT: COUNT=10, CHANNELS=3. Two single-channel DUTs (COUNT=2, COUNT=16)
//   cover the WIDTH=1 and WIDTH=4 power-of-two corners. Each step() computes
//   the expected outputs from a behavioural reference model, pushes them to a
//   scoreboard queue, then pops and compares after the clock edge.
//   Honours UPDOWN_COUNTER_CASCADE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_updown_counter_bank;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic [2:0]  inc, dec, load, sat;
    logic [11:0] ld_val;
    logic [11:0] cnt;
    logic [2:0]  wu, wd, amax, azero;

    logic        s_inc, s_dec, s_load, s_sat;
    logic        s_lv2;
    logic [3:0]  s_lv16;
    logic        c2, c2wu, c2wd, c2max, c2zero;
    logic [3:0]  c16;
    logic        c16wu, c16wd, c16max, c16zero;

    updown_counter_bank #(.COUNT(10), .CHANNELS(3)) u_dut (
        .clock(clock), .reset_n(reset_n), .i_inc(inc), .i_dec(dec), .i_load(load),
        .i_load_val(ld_val), .i_sat(sat), .o_count(cnt), .o_wrap_up(wu),
        .o_wrap_dn(wd), .o_at_max(amax), .o_at_zero(azero)
    );

    updown_counter_bank #(.COUNT(2), .CHANNELS(1)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .i_inc(s_inc), .i_dec(s_dec), .i_load(s_load),
        .i_load_val(s_lv2), .i_sat(s_sat), .o_count(c2), .o_wrap_up(c2wu),
        .o_wrap_dn(c2wd), .o_at_max(c2max), .o_at_zero(c2zero)
    );

    updown_counter_bank #(.COUNT(16), .CHANNELS(1)) u_dut16 (
        .clock(clock), .reset_n(reset_n), .i_inc(s_inc), .i_dec(s_dec), .i_load(s_load),
        .i_load_val(s_lv16), .i_sat(s_sat), .o_count(c16), .o_wrap_up(c16wu),
        .o_wrap_dn(c16wd), .o_at_max(c16max), .o_at_zero(c16zero)
    );

    typedef struct {
        logic [11:0] cnt;
        logic [2:0]  wu, wd, amax, azero;
        logic        c2, c2wu, c2wd, c2max, c2zero;
        logic [3:0]  c16;
        logic        c16wu, c16wd, c16max, c16zero;
    } exp_t;

    exp_t sb_q[$];
    int   m_cnt[3];
    int   m2, m16;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_txn = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    // Reference behaviour of one counter channel with modulus m.
    function automatic void model_ch(input int cur, input bit ld, input int lv,
                                     input bit up, input bit dn, input bit sm, input int m,
                                     output int nxt, output bit wrap_u, output bit wrap_d);
        nxt = cur; wrap_u = 0; wrap_d = 0;
        if (ld) begin
            nxt = (lv >= m) ? m - 1 : lv;
        end else if (up && !dn) begin
            if (cur < m - 1)  nxt = cur + 1;
            else if (!sm) begin nxt = 0; wrap_u = 1; end
        end else if (dn && !up) begin
            if (cur > 0)      nxt = cur - 1;
            else if (!sm) begin nxt = m - 1; wrap_d = 1; end
        end
    endfunction

    task automatic step();
        exp_t e;
        int   nxt;
        bit   u, d, cu, cd;
        cu = 0; cd = 0;
        for (int k = 0; k < 3; k++) begin
            bit ie, de;
            ie = inc[k]; de = dec[k];
`ifdef UPDOWN_COUNTER_CASCADE_EN
            ie = ie | cu;
            de = de | cd;
`endif
            model_ch(m_cnt[k], load[k], int'(ld_val[k*4 +: 4]), ie, de, sat[k], 10, nxt, u, d);
            cu = u; cd = d;
            if (!reset_n) begin nxt = 0; u = 0; d = 0; end
            m_cnt[k]         = nxt;
            e.cnt[k*4 +: 4]  = 4'(nxt);
            e.wu[k]          = u;
            e.wd[k]          = d;
            e.amax[k]        = (nxt == 9);
            e.azero[k]       = (nxt == 0);
        end
        model_ch(m2, s_load, int'(s_lv2), s_inc, s_dec, s_sat, 2, nxt, u, d);
        if (!reset_n) begin nxt = 0; u = 0; d = 0; end
        m2 = nxt; e.c2 = (nxt == 1); e.c2wu = u; e.c2wd = d;
        e.c2max = (nxt == 1); e.c2zero = (nxt == 0);
        model_ch(m16, s_load, int'(s_lv16), s_inc, s_dec, s_sat, 16, nxt, u, d);
        if (!reset_n) begin nxt = 0; u = 0; d = 0; end
        m16 = nxt; e.c16 = 4'(nxt); e.c16wu = u; e.c16wd = d;
        e.c16max = (nxt == 15); e.c16zero = (nxt == 0);
        sb_q.push_back(e);

        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        n_txn++;
        check_val("count",    32'(cnt),   32'(e.cnt));
        check_val("wrap_up",  32'(wu),    32'(e.wu));
        check_val("wrap_dn",  32'(wd),    32'(e.wd));
        check_val("at_max",   32'(amax),  32'(e.amax));
        check_val("at_zero",  32'(azero), 32'(e.azero));
        check_val("c2_count", 32'({c2, c2wu, c2wd, c2max, c2zero}),
                  32'({e.c2, e.c2wu, e.c2wd, e.c2max, e.c2zero}));
        check_val("c16_count", 32'(c16), 32'(e.c16));
        check_val("c16_flags", 32'({c16wu, c16wd, c16max, c16zero}),
                  32'({e.c16wu, e.c16wd, e.c16max, e.c16zero}));
        $display("txn %0d rst_n=%b inc=%b dec=%b load=%b sat=%b cnt=%h wu=%b wd=%b | c2=%b c16=%h",
                 n_txn, reset_n, inc, dec, load, sat, cnt, wu, wd, c2, c16);
    endtask

    initial begin
        reset_n = 1'b0; inc = 3'b111; dec = 3'b000; load = 3'b000; sat = 3'b000; ld_val = '0;
        s_inc = 1'b1; s_dec = 1'b0; s_load = 1'b0; s_sat = 1'b0; s_lv2 = 1'b0; s_lv16 = '0;

        // 1: reset dominates active strobes, counting resumes after release
        repeat (2) step();
        reset_n = 1'b1; inc = 3'b000; s_inc = 1'b0;
        step();
        check_val("t1_after_reset", 32'(cnt), 32'h0);
        inc = 3'b001;
        step();
        check_val("t1_resume", 32'(cnt[3:0]), 32'h1);

        // 2: channel 0 wraps after ten increments
        inc = 3'b000; load = 3'b111; ld_val = '0;
        step();
        load = 3'b000; inc = 3'b001;
        repeat (10) step();
        check_val("t2_ch0_zero", 32'(cnt[3:0]), 32'h0);
        check_val("t2_wrap_pulse", 32'(wu[0]), 32'h1);
        inc = 3'b000;
        step();
        check_val("t2_pulse_drop", 32'(wu[0]), 32'h0);

        // 3: channel 1 saturating at both ends
        sat = 3'b010; load = 3'b010; ld_val = '0;
        step();
        load = 3'b000; dec = 3'b010;
        repeat (2) step();
        check_val("t3_sat_zero", 32'({cnt[7:4], wd[1]}), 32'h00);
        dec = 3'b000; load = 3'b010; ld_val = 12'h090;
        step();
        load = 3'b000; inc = 3'b010;
        repeat (2) step();
        check_val("t3_sat_max", 32'({cnt[7:4], wu[1]}), 32'h12);

        // 4: load wins over inc and is clamped; inc&dec together hold
        inc = 3'b100; load = 3'b100; ld_val = 12'hC00;
        step();
        check_val("t4_clamp", 32'(cnt[11:8]), 32'h9);
        load = 3'b000; inc = 3'b111; dec = 3'b111;
        step();

        // 5: carry ripple across all digits (cascade build only)
        inc = 3'b000; dec = 3'b000; sat = 3'b000; load = 3'b111; ld_val = 12'h999;
        step();
        load = 3'b000; inc = 3'b001;
        step();
`ifdef UPDOWN_COUNTER_CASCADE_EN
        check_val("t5_ripple", 32'({cnt, wu}), 32'({12'h000, 3'b111}));
`else
        check_val("t5_indep", 32'({cnt, wu}), 32'({12'h990, 3'b001}));
`endif
        inc = 3'b000;

        // 6: COUNT=2 / COUNT=16 full wrap sequences, then saturation
        s_load = 1'b1; s_lv2 = 1'b0; s_lv16 = 4'd0;
        step();
        s_load = 1'b0; s_inc = 1'b1;
        repeat (18) step();
        s_inc = 1'b0; s_dec = 1'b1;
        repeat (18) step();
        s_sat = 1'b1;
        repeat (3) step();
        s_dec = 1'b0; s_inc = 1'b1;
        repeat (17) step();

        // Mixed random traffic on everything
        for (int i = 0; i < 40; i++) begin
            inc    = 3'($urandom);
            dec    = 3'($urandom);
            sat    = 3'($urandom);
            load   = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            ld_val = 12'($urandom);
            s_inc  = 1'($urandom); s_dec = 1'($urandom); s_sat = 1'($urandom);
            s_load = ($urandom_range(0, 7) == 0);
            s_lv2  = 1'($urandom); s_lv16 = 4'($urandom);
            reset_n = (i != 25);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
